// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: EX-side initiator for the HI/LO mul/div unit; holds Start/Op/operands for the
// fixed op latency and stalls HI/LO users in ID. Define MD_CHECK_EN for the sticky busy_err checker.
module md_issue_ctrl #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10,
  parameter int CNT_W      = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [3:0]  ex_op,
  input  logic [31:0] ex_rs,
  input  logic [31:0] ex_rt,
  input  logic        id_md_use,
  input  logic        md_busy,
  input  logic [31:0] md_hi,
  input  logic [31:0] md_lo,
  output logic        md_start,
  output logic [3:0]  md_op,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  output logic        stall,
  output logic [31:0] ex_rdata,
  output logic        busy_err
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, WR = 2'd2} state_t;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             is_md_s;
  logic             is_mt_s;
  logic             issue_now_s;
  logic             run_done_s;
  logic [CNT_W-1:0] run_len_s;

  // Decode the EX op, the end of the current run, and the ID stall
  always_comb begin
    if (ex_valid) begin
      is_md_s = (ex_op >= OP_MULT) && (ex_op <= OP_DIVU);
      is_mt_s = (ex_op == OP_MTHI) || (ex_op == OP_MTLO);
    end else begin
      is_md_s = 1'b0;
      is_mt_s = 1'b0;
    end
    issue_now_s = (state_r == IDLE) && (is_md_s || is_mt_s);
    if ((md_op == OP_MULT) || (md_op == OP_MULTU)) begin
      run_len_s = CNT_W'(MUL_CYCLES);
    end else begin
      run_len_s = CNT_W'(DIV_CYCLES);
    end
    run_done_s = (cnt_r == run_len_s);
    stall      = id_md_use && ((state_r != IDLE) || issue_now_s);
  end

  // MFHI/MFLO read-back; only reachable in IDLE because of the stall
  always_comb begin
    case (ex_op)
      OP_MFHI: ex_rdata = md_hi;
      OP_MFLO: ex_rdata = md_lo;
      default: ex_rdata = 32'd0;
    endcase
  end

  // Issue FSM: operands are frozen for the whole run and md_op returns to 0 in IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      cnt_r    <= '0;
      md_start <= 1'b0;
      md_op    <= OP_NONE;
      md_a     <= 32'd0;
      md_b     <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (issue_now_s && is_md_s) begin
            md_op    <= ex_op;
            md_a     <= ex_rs;
            md_b     <= ex_rt;
            md_start <= 1'b1;
            cnt_r    <= CNT_W'(1'b1);
            state_r  <= RUN;
          end else if (issue_now_s) begin
            // The unit takes MTLO data on RData2, so rs goes to both operands
            md_op   <= ex_op;
            md_a    <= ex_rs;
            md_b    <= ex_rs;
            state_r <= WR;
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          if (run_done_s) begin
            md_start <= 1'b0;
            md_op    <= OP_NONE;
            cnt_r    <= '0;
            state_r  <= IDLE;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1'b1);
          end
        end
        WR: begin
          md_op   <= OP_NONE;
          state_r <= IDLE;
        end
        default: begin
          md_start <= 1'b0;
          md_op    <= OP_NONE;
          cnt_r    <= '0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

`ifdef MD_CHECK_EN
  logic after_run_r;
  logic idle_seen_r;

  // Sticky protocol checker against the unit's Busy (Busy lags md_start by one edge)
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_err    <= 1'b0;
      after_run_r <= 1'b0;
      idle_seen_r <= 1'b0;
    end else begin
      if ((state_r == RUN) && run_done_s) begin
        after_run_r <= 1'b1;
      end else begin
        after_run_r <= after_run_r;
      end
      idle_seen_r <= (state_r == IDLE);
      busy_err    <= busy_err
                   | ((state_r == RUN) && (cnt_r >= CNT_W'(2'd2)) && !md_busy)
                   | ((state_r == IDLE) && idle_seen_r && after_run_r && md_busy)
                   | ((state_r != IDLE) && (is_md_s || is_mt_s));
    end
  end
`else
  logic unused_busy_s;
  assign unused_busy_s = md_busy;

  // Checker compiled out: flag held low
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_err <= 1'b0;
    end else begin
      busy_err <= 1'b0;
    end
  end
`endif

endmodule

// File: doc/md_issue_ctrl.md
Name: md_issue_ctrl

Overview:
Pipeline-side initiator for the HI/LO multiply/divide unit. It takes the decoded HI/LO instruction in EX and drives the unit's Start/Op/operand inputs, holding them for the fixed operation latency. It generates the ID-stage stall for any HI/LO-using instruction while an operation is in flight, and returns HI/LO read data for MFHI/MFLO. It sits between the EX stage and the mul/div unit, beside the hazard unit.

Parameters:
MUL_CYCLES, 5, cycles md_start is held for MULT/MULTU (must equal the unit's multiply count)
DIV_CYCLES, 10, cycles md_start is held for DIV/DIVU
CNT_W, 4, counter width; must hold DIV_CYCLES

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
ex_valid  in  1  EX-stage instruction valid (not bubble)
ex_op  in  4  EX HI/LO op: 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO
ex_rs  in  32  forwarded rs operand
ex_rt  in  32  forwarded rt operand
id_md_use  in  1  ID-stage instruction is any of ops 1-8
md_busy  in  1  Busy from the mul/div unit
md_hi  in  32  HI_Outcome from the unit
md_lo  in  32  LO_Outcome from the unit
md_start  out  1  Start to the unit
md_op  out  4  Op to the unit (codes 0-6 only)
md_a  out  32  RData1 to the unit
md_b  out  32  RData2 to the unit
stall  out  1  freeze PC/IF/ID and bubble EX
ex_rdata  out  32  MFHI/MFLO result for EX
busy_err  out  1  protocol-error flag (see Optional Feature)

Behaviour:
- The block is always clocked by clk; reset is synchronous and active-high.
- Reset values (next edge, including mid-operation): state IDLE, counter 0, md_start 0, md_op 0, md_a 0, md_b 0, busy_err 0. An aborted operation is dropped.
- FSM states are IDLE, RUN, WR.
- IDLE:
  - Issue when ex_valid and ex_op is 1-4. On that edge: md_op<=ex_op, md_a<=ex_rs, md_b<=ex_rt, md_start<=1, counter<=1, go to RUN.
  - When ex_valid and ex_op is 5 or 6: md_op<=ex_op, md_a<=ex_rs, md_b<=ex_rs (the unit takes MTLO data on RData2), md_start stays 0, go to WR.
- RUN:
  - md_start, md_op, md_a and md_b are held stable.
  - counter increments each cycle. When counter==MUL_CYCLES (ops 1/2) or DIV_CYCLES (ops 3/4), the next edge sets md_start<=0, md_op<=0, counter<=0 and returns to IDLE.
  - Total start-high time is exactly MUL_CYCLES or DIV_CYCLES cycles.
- WR: lasts one cycle; md_op<=0, then IDLE.
- md_op is 0 in IDLE, so the unit never recomputes on stale operands.
- stall = id_md_use & (state!=IDLE | issue_now), where issue_now = IDLE & ex_valid & ex_op in 1..6. This is combinational. Non-HI/LO instructions never stall, so the pipeline overlaps them with the operation.
- ex_rdata (combinational):
  - ex_op==7 gives md_hi; ex_op==8 gives md_lo; otherwise 0.
  - MFHI/MFLO can reach EX only in IDLE, because stall guarantees it.
- ex_valid=0 or ex_op 7/8 never changes state.
- The unit treats divide by zero as a no-op. This block still runs the full DIV_CYCLES, so timing is data-independent.
- ex_valid with ex_op 1-6 while not in IDLE is illegal. It is ignored: no re-issue and no operand change.

Optional Feature:
MD_CHECK_EN:
- Defined: a sticky busy_err is set on any of these conditions, and cleared only by reset:
  - md_busy is 0 during RUN cycles 2..N, where N is MUL_CYCLES or DIV_CYCLES (the unit first raises Busy on the edge after md_start rises);
  - md_busy is 1 in IDLE one or more cycles after returning from RUN;
  - an illegal ex_op 1-6 arrives outside IDLE.
- Undefined: busy_err is tied to 0 and md_busy is unused.

Test Plan:
- Reset, then ex_valid=1, ex_op=1 (MULT), rs=7, rt=-3 for one cycle -> md_start high for exactly 5 cycles with md_op=1, md_a=7, md_b=0xFFFFFFFD held; then md_op=0; afterwards MFLO gives ex_rdata=0xFFFFFFEB and MFHI gives 0xFFFFFFFF.
- DIVU, rs=100, rt=7; id_md_use=1 asserted from the cycle after issue -> stall high for 10 cycles, low on the IDLE cycle; MFHI=2, MFLO=14.
- MTHI with rs=0x12345678 -> md_op=5 for one cycle, md_start=0; next cycle MFHI gives 0x12345678; MTLO with 0xABCD gives MFLO 0xABCD.
- reset asserted at RUN cycle 4 of a DIV -> on the next edge md_start=0, md_op=0, state IDLE, stall=0 even with id_md_use=1.
- DIV by 0 after MTLO 5 -> 10-cycle run completes, MFLO still 5; an independent ADD in ID during the run never stalls.
- With MD_CHECK_EN defined, tie md_busy=0 during a MULT -> busy_err=1 at RUN cycle 2 and it stays 1 until reset; without the macro busy_err=0.
